// File: rtl/onehot_ptr.sv
// Rotating one-hot pointer: loadable binary index with a masked,
// wrap-around advance, registered one-hot decode and a mask-empty flag.
module onehot_ptr #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 LoadEn,
   input  logic [$clog2(N)-1:0] LoadIdx,
   input  logic                 AdvEn,
   input  logic [N-1:0]         Mask,
   output logic [N-1:0]         Y,
   output logic [$clog2(N)-1:0] Idx,
   output logic                 Empty
);

   localparam int W = $clog2(N);

   logic [W-1:0] adv_idx;
   logic [W-1:0] next_idx;
   logic [W-1:0] cand;
   logic         found;

   // First enabled position after Idx, wrapping; k=N lands back on Idx itself.
   always_comb begin
      adv_idx = Idx;
      found   = 1'b0;
      cand    = Idx;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = Idx + W'(k);
         if (!found && Mask[cand]) begin
            adv_idx = cand;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      next_idx = Idx;
      if (LoadEn)
         next_idx = LoadIdx;
      else if (AdvEn)
         next_idx = adv_idx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Idx <= '0;
         Y   <= N'(1);
      end else begin
         Idx <= next_idx;
         Y   <= N'(1) << next_idx;
      end
   end

   assign Empty = ~|Mask;

endmodule

// File: tb/tb_onehot_ptr.sv
// Randomized and directed self-checking bench for onehot_ptr (N=4),
// compared against a set-based reference model of the pointer.
module tb_onehot_ptr;

   localparam int N = 4;
   localparam int W = $clog2(N);

   logic         clk = 1'b0;
   logic         reset;
   logic         LoadEn;
   logic [W-1:0] LoadIdx;
   logic         AdvEn;
   logic [N-1:0] Mask;
   logic [N-1:0] Y;
   logic [W-1:0] Idx;
   logic         Empty;

   int errors = 0;
   int checks = 0;
   int m_ptr  = 0;

   onehot_ptr #(.N(N)) dut (
      .clk     (clk),
      .reset   (reset),
      .LoadEn  (LoadEn),
      .LoadIdx (LoadIdx),
      .AdvEn   (AdvEn),
      .Mask    (Mask),
      .Y       (Y),
      .Idx     (Idx),
      .Empty   (Empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Smallest enabled position above p, else the lowest enabled one overall,
   // else no move.
   function automatic int next_enabled(input int p, input logic [N-1:0] m);
      int above  = -1;
      int lowest = -1;
      for (int i = 0; i < N; i++) begin
         if (m[i]) begin
            if (lowest < 0) lowest = i;
            if (i > p && above < 0) above = i;
         end
      end
      if (above >= 0) return above;
      if (lowest >= 0) return lowest;
      return p;
   endfunction

   task automatic drive(input logic le, input int li, input logic ae, input logic [N-1:0] m);
      LoadEn  = le;
      LoadIdx = W'(li);
      AdvEn   = ae;
      Mask    = m;
   endtask

   task automatic cycle(input string tag);
      if (reset) m_ptr = 0;
      else if (LoadEn) m_ptr = int'(LoadIdx);
      else if (AdvEn) m_ptr = next_enabled(m_ptr, Mask);
      @(posedge clk);
      #1;
      check({tag, ".idx"}, int'(Idx), m_ptr);
      check({tag, ".y"}, int'(Y), 1 << m_ptr);
      check({tag, ".empty"}, int'(Empty), (Mask == '0) ? 1 : 0);
   endtask

   task automatic async_reset_pulse(input string tag);
      #2;
      reset = 1'b1;
      #1;
      m_ptr = 0;
      check({tag, ".rst_idx"}, int'(Idx), 0);
      check({tag, ".rst_y"}, int'(Y), 1);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 0, 1'b0, '0);
      #3;
      check("por.idx", int'(Idx), 0);
      check("por.y", int'(Y), 1);
      check("por.empty", int'(Empty), 1);
      @(negedge clk);
      reset = 1'b0;

      // Reset between edges, then load attempt while held in reset
      drive(1'b1, 3, 1'b0, 4'hF);
      cycle("load3");
      async_reset_pulse("midreset");
      drive(1'b1, 2, 1'b0, 4'hF);
      cycle("load_in_reset");
      #2;
      reset = 1'b0;
      drive(1'b0, 0, 1'b0, 4'hF);
      cycle("hold_after_reset");

      // Load ignores an all-zero mask
      drive(1'b1, 2, 1'b0, 4'h0);
      cycle("load_masked");

      // Wrap-around
      drive(1'b1, 3, 1'b0, 4'hF);
      cycle("wrap_setup");
      drive(1'b0, 0, 1'b1, 4'hF);
      for (int i = 0; i < 4; i++) cycle("wrap_adv");

      // Sparse mask, then single enabled position equal to Idx
      drive(1'b1, 0, 1'b0, 4'hF);
      cycle("sparse_setup");
      drive(1'b0, 0, 1'b1, 4'b1010);
      for (int i = 0; i < 3; i++) cycle("sparse_adv");
      drive(1'b1, 0, 1'b0, 4'hF);
      cycle("single_setup");
      drive(1'b0, 0, 1'b1, 4'b0001);
      cycle("single_self");

      // Load beats advance; empty mask freezes advance
      drive(1'b1, 2, 1'b1, 4'hF);
      cycle("load_prio");
      drive(1'b0, 0, 1'b1, 4'h0);
      cycle("adv_empty");

      // Mask change alone does not move the pointer
      drive(1'b0, 0, 1'b0, 4'b0001);
      cycle("mask_only");

      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)),
               ($urandom_range(0, 3) != 0), N'($urandom));
         if ($urandom_range(0, 39) == 0) begin
            async_reset_pulse("rnd_reset");
            cycle("rnd_in_reset");
            #2;
            reset = 1'b0;
         end else begin
            cycle("rnd");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/onehot_ptr.md
ONEHOT_PTR -- requirements
Module: onehot_ptr

Interface
REQ-001 SHALL have parameter: N, default 4, number of one-hot positions; legal values are powers of two, N >= 2.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: LoadEn  input  1  load pointer from LoadIdx this cycle.
REQ-005 SHALL have port: LoadIdx  input  $clog2(N)  binary index to load.
REQ-006 SHALL have port: AdvEn  input  1  advance pointer to the next enabled position this cycle.
REQ-007 SHALL have port: Mask  input  N  per-position enable; bit k=1 means position k may be selected by an advance.
REQ-008 SHALL have port: Y  output  N  registered one-hot decode of the pointer.
REQ-009 SHALL have port: Idx  output  $clog2(N)  registered binary pointer.
REQ-010 SHALL have port: Empty  output  1  combinational; high when Mask has no bit set.

Function
REQ-011 SHALL hold a binary pointer register Idx; Y SHALL equal the one-hot decode of Idx in every cycle (Y[Idx]=1, all other bits 0).
REQ-012 SHALL register Y and Idx on the same edge; no combinational path from any input to Y or Idx.
REQ-013 Latency: a LoadEn or AdvEn sampled at edge t SHALL be visible on Y/Idx immediately after edge t (one-cycle latency from request cycle).
REQ-014 Load: when LoadEn=1, Idx SHALL become LoadIdx regardless of Mask (a masked position may be loaded).
REQ-015 Advance: when AdvEn=1 and LoadEn=0, Idx SHALL become (Idx+k) mod N for the smallest k in 1..N with Mask[(Idx+k) mod N]=1.
REQ-016 Wrap-around: the advance search SHALL wrap from position N-1 to position 0 with no dead cycle.
REQ-017 Single enabled position equal to the current Idx: advance SHALL leave Idx unchanged (k=N case).
REQ-018 Mask all zero: advance SHALL leave Idx and Y unchanged; Empty SHALL be 1 in that cycle.
REQ-019 Simultaneous LoadEn and AdvEn: load SHALL take priority; advance is discarded, not deferred.
REQ-020 Neither LoadEn nor AdvEn: Idx and Y SHALL hold.
REQ-021 Mask changes SHALL take effect on the next advance only; a Mask change alone SHALL NOT move Idx.
REQ-022 Empty SHALL equal the NOR of Mask with no register stage.
REQ-023 The advance search SHALL be a single-cycle combinational rotate-and-priority-select over N positions; no multi-cycle search.

Reset
REQ-024 On reset assertion, asynchronously and without waiting for clk, Idx SHALL be 0 and Y SHALL be one-hot with bit 0 set.
REQ-025 While reset is high, LoadEn and AdvEn SHALL be ignored; Empty continues to follow Mask.
REQ-026 Reset asserted mid-operation SHALL discard any in-progress load/advance of that cycle; first update after release occurs at the first rising edge with reset low.

Verification (N=4)
REQ-027 Reset: drive Idx to 3, assert reset between edges -> Y=0001, Idx=0 before the next edge; LoadEn=1 during reset -> no change.
REQ-028 Load: Idx=0, LoadEn=1, LoadIdx=2, Mask=0000 -> after edge Idx=2, Y=0100, Empty=1.
REQ-029 Wrap: Idx=3, Mask=1111, AdvEn=1 -> Idx=0, Y=0001; three more advances -> 1, 2, 3.
REQ-030 Sparse mask: Idx=0, Mask=1010, AdvEn held 3 cycles -> Idx 1, 3, 1; Mask=0001 from Idx=0, advance -> Idx stays 0.
REQ-031 Priority/empty: Idx=0, LoadEn=1, LoadIdx=2, AdvEn=1, Mask=1111 -> Idx=2 (not 3); then Mask=0000, AdvEn=1 -> Idx stays 2, Empty=1.
